// File: rtl/sim_pkg.sv
// Shared definitions for the sparse Ising machine field/bias stages:
// controller states, spin encoding and register-file address sizing.
package sim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } acc_state_t;

  localparam logic SPIN_POS = 1'b1;
  localparam logic SPIN_NEG = 1'b0;

  // Address width for n weights plus one bias slot; never narrower than 1 bit.
  function automatic int addr_w(input int n);
    return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sat_clamp.sv
// Signed saturator: narrows an IN_W-bit value to OUT_W bits, clamping
// anything outside the representable range to the nearest limit.
module sat_clamp #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  localparam logic signed [IN_W-1:0] MAX_V = IN_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] MIN_V = -MAX_V - IN_W'(1);

  always_comb begin
    dout = din[OUT_W-1:0];
    if (din > MAX_V) begin
      dout = MAX_V[OUT_W-1:0];
    end else if (din < MIN_V) begin
      dout = MIN_V[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/local_field_accumulator.sv
// Local field I_i = h_i + sum_j J_ij * m_j for one spin: serial MAC over the
// neighbours (one per clock), then saturation to the p_bit input width.
module local_field_accumulator
  import sim_pkg::*;
#(
  parameter int NUM_NEIGHBORS = 4,
  parameter int WEIGHT_W      = 4,
  parameter int ACC_W         = 8,
  parameter int OUT_W         = 4,
  parameter int ADDR_W        = addr_w(NUM_NEIGHBORS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_NEIGHBORS-1:0]   spins,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic signed [WEIGHT_W-1:0] wr_data,
  output logic                       busy,
  output logic                       field_valid,
  output logic signed [OUT_W-1:0]    field_out
);

  localparam int IDX_W = (NUM_NEIGHBORS > 1) ? $clog2(NUM_NEIGHBORS) : 1;

  acc_state_t state_reg, state_next;

  logic signed [WEIGHT_W-1:0] weight_reg [NUM_NEIGHBORS];
  logic signed [WEIGHT_W-1:0] bias_reg;
  logic [NUM_NEIGHBORS-1:0]   snap_reg;
  logic [IDX_W-1:0]           index_reg;
  logic signed [ACC_W-1:0]    acc_reg;
  logic signed [ACC_W-1:0]    weight_ext;
  logic signed [ACC_W-1:0]    bias_ext;
  logic signed [ACC_W-1:0]    term;
  logic signed [OUT_W-1:0]    clamped;
  logic                       last_index;

  assign last_index = (index_reg == IDX_W'(NUM_NEIGHBORS - 1));
  assign busy       = (state_reg != ST_IDLE);

  // Negate after sign extension so the most negative weight flips cleanly.
  always_comb begin
    weight_ext = {{(ACC_W-WEIGHT_W){weight_reg[index_reg][WEIGHT_W-1]}}, weight_reg[index_reg]};
    bias_ext   = {{(ACC_W-WEIGHT_W){bias_reg[WEIGHT_W-1]}}, bias_reg};
    term       = (snap_reg[index_reg] == SPIN_POS) ? weight_ext : -weight_ext;
  end

  sat_clamp #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_W)
  ) u_sat_clamp (
    .din  (acc_reg),
    .dout (clamped)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_ACCUM;
      ST_ACCUM: if (last_index) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Register file: writes land only while idle; out-of-range addresses drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_NEIGHBORS; i++) weight_reg[i] <= '0;
      bias_reg <= '0;
    end else if (wr_en && state_reg == ST_IDLE) begin
      for (int i = 0; i < NUM_NEIGHBORS; i++) begin
        if (wr_addr == ADDR_W'(i)) weight_reg[i] <= wr_data;
      end
      if (wr_addr == ADDR_W'(NUM_NEIGHBORS)) bias_reg <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_reg    <= '0;
      index_reg   <= '0;
      acc_reg     <= '0;
      field_out   <= '0;
      field_valid <= 1'b0;
    end else begin
      field_valid <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            snap_reg  <= spins;
            acc_reg   <= bias_ext;
            index_reg <= '0;
          end
        end
        ST_ACCUM: begin
          acc_reg   <= acc_reg + term;
          index_reg <= index_reg + IDX_W'(1);
        end
        ST_DONE: begin
          field_out   <= clamped;
          field_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
